// File: rtl/fifo_pkg.sv
// Shared types, defaults and helpers for the synchronous FIFO family.
package fifo_pkg;

    // Read-side behaviour selected at build time.
    typedef enum logic {
        FIFO_REG  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Default thresholds: almost_empty at <= 2 words, almost_full at DEPTH-2 words.
    localparam int unsigned DEFAULT_AE_THRESH = 2;
    localparam int unsigned DEFAULT_AF_MARGIN = 2;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// FIFO storage: register array with a synchronous write port and an
// asynchronous read port. Contents are not reset; the pointers define validity.
module fifo_mem_dp #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port: store one word per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with programmable almost-full/almost-empty
// thresholds, live fill count, sticky error flags, synchronous flush and a
// build-time choice of registered or first-word-fall-through read.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_THRESH  = DEPTH - DEFAULT_AF_MARGIN,
    parameter int unsigned AE_THRESH  = DEFAULT_AE_THRESH,
    parameter int unsigned FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     w_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     r_en,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam fifo_mode_e  MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_REG;
    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 4");
    end
    if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
        $fatal(1, "sync_fifo_param: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
    end

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_s, empty_s;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Status from registered pointers only, so it is glitch-free within a cycle.
    assign empty_s = (wptr_q == rptr_q);
    assign full_s  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

    // Flush blocks both ports; full/empty are pre-edge so a full FIFO still reads.
    assign wr_acc = w_en && !full_s && !flush;
    assign rd_acc = r_en && !empty_s && !flush;

    fifo_mem_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr_q[AW-1:0]),
        .wdata (data_in),
        .raddr (rptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    // Next-state for pointers and fill count.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PW'(1);
            if (rd_acc) rptr_d = rptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Next-state for sticky error flags; a new error wins over clr_err.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (w_en && full_s && !flush)  overflow_d  = 1'b1;
        if (r_en && empty_s && !flush) underflow_d = 1'b1;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    if (MODE == FIFO_REG) begin : g_reg_out
        logic [DATA_WIDTH-1:0] dout_q;

        // Output register loads only on an accepted read and holds otherwise.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_rdata;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_out
        // Head word is shown directly; zero when nothing is stored.
        assign data_out = empty_s ? '0 : mem_rdata;
    end

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
